// File: rtl/serial_frame_pkg.sv
// Shared framing definitions for the serial receive/transmit stages.
package serial_frame_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Line idles low, so a start bit is a 1 and the stop bit returns to 0.
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/serial_parity_acc.sv
// Running XOR of serial bits; reports the parity bit the frame should carry.
module serial_parity_acc
    import serial_frame_pkg::*;
#(
    parameter bit EVEN = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic exp_bit_c
);

    logic acc;

    // Accumulate XOR of every enabled bit; clear has priority over enable.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

    // Even parity: bit equals data XOR; odd parity: its complement.
    assign exp_bit_c = EVEN ? acc : ~acc;

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed-word receiver: start bit, WIDTH data bits, optional parity, stop bit.
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH     = 5,
    parameter bit          PARITY_EN = 1'b1,
    parameter bit          EVEN      = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SI,
    input  logic             EN,
    input  logic             LR,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic             PERR,
    output logic             FERR,
    output logic             BUSY
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             lr_q, lr_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] dout_d;
    logic             perr_d;
    logic             dvalid_d;
    logic             ferr_d;
    logic             busy_d;
    logic             par_clr_c;
    logic             par_en_c;
    logic             exp_bit_c;

    serial_parity_acc #(
        .EVEN (EVEN)
    ) u_parity (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (par_clr_c),
        .en        (par_en_c),
        .bit_in    (SI),
        .exp_bit_c (exp_bit_c)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output decode; everything holds unless EN strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        lr_d      = lr_q;
        mis_d     = mis_q;
        dout_d    = DOUT;
        perr_d    = PERR;
        dvalid_d  = 1'b0;
        ferr_d    = 1'b0;
        par_clr_c = 1'b0;
        par_en_c  = 1'b0;
        if (EN) begin
            case (state_q)
                S_IDLE: begin
                    if (SI == START_LVL) begin
                        state_d   = S_DATA;
                        lr_d      = LR;
                        cnt_d     = '0;
                        shreg_d   = '0;
                        mis_d     = 1'b0;
                        par_clr_c = 1'b1;
                    end
                end
                S_DATA: begin
                    // MSB-first shifts left into bit 0; LSB-first shifts right into the top.
                    if (lr_q) begin
                        shreg_d = {shreg_q[WIDTH-2:0], SI};
                    end else begin
                        shreg_d = {SI, shreg_q[WIDTH-1:1]};
                    end
                    par_en_c = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    mis_d   = (SI != exp_bit_c);
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // A 1 here is a framing error, never a new start bit.
                    if (SI == STOP_LVL) begin
                        dout_d   = shreg_q;
                        perr_d   = PARITY_EN ? mis_q : 1'b0;
                        dvalid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            lr_q    <= 1'b0;
            mis_q   <= 1'b0;
            DOUT    <= '0;
            PERR    <= 1'b0;
            DVALID  <= 1'b0;
            FERR    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            lr_q    <= lr_d;
            mis_q   <= mis_d;
            DOUT    <= dout_d;
            PERR    <= perr_d;
            DVALID  <= dvalid_d;
            FERR    <= ferr_d;
            BUSY    <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (WIDTH=5, parity on, even).
module tb_serial_frame_receiver;

    logic       CLK;
    logic       RST;
    logic       SI;
    logic       EN;
    logic       LR;
    logic [4:0] DOUT;
    logic       DVALID;
    logic       PERR;
    logic       FERR;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;

    serial_frame_receiver #(
        .WIDTH     (5),
        .PARITY_EN (1'b1),
        .EVEN      (1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SI     (SI),
        .EN     (EN),
        .LR     (LR),
        .DOUT   (DOUT),
        .DVALID (DVALID),
        .PERR   (PERR),
        .FERR   (FERR),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count output pulses, sampled mid-cycle.
    always @(negedge CLK) begin
        if (DVALID === 1'b1) dv_cnt++;
        if (FERR === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the edge.
    task automatic step(input logic si, input logic en);
        SI = si;
        EN = en;
        @(posedge CLK);
        #1;
    endtask

    // Send 8 frame bits MSB of the vector first; alt inserts EN=0 cycles with random SI.
    task automatic send_frame(input logic [7:0] f, input bit alt);
        for (int i = 7; i >= 0; i--) begin
            if (alt) step(1'($urandom), 1'b0);
            step(f[i], 1'b1);
        end
    endtask

    localparam logic [7:0] FR_GOOD = 8'b1101_1010; // start,1,0,1,1,0,par=1,stop=0
    localparam logic [7:0] FR_PBAD = 8'b1101_1000; // parity flipped to 0
    localparam logic [7:0] FR_SBAD = 8'b1101_1011; // stop bit 1

    initial begin
        RST = 1'b0;
        SI  = 1'b0;
        EN  = 1'b0;
        LR  = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_dout", 32'(DOUT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_dvalid", 32'(DVALID), 32'h0);
        chk("rst_perr", 32'(PERR), 32'h0);
        chk("rst_ferr", 32'(FERR), 32'h0);
        RST = 1'b1;
        step(1'b0, 1'b1);
        chk("idle_busy", 32'(BUSY), 32'h0);

        // Case 1: MSB first.
        LR = 1'b1;
        step(1'b1, 1'b1);
        chk("c1_busy_start", 32'(BUSY), 32'h1);
        for (int i = 6; i >= 0; i--) step(FR_GOOD[i], 1'b1);
        chk("c1_dvalid", 32'(DVALID), 32'h1);
        chk("c1_dout", 32'(DOUT), 32'h16);
        chk("c1_perr", 32'(PERR), 32'h0);
        chk("c1_ferr", 32'(FERR), 32'h0);
        chk("c1_busy_end", 32'(BUSY), 32'h0);
        step(1'b0, 1'b1);
        chk("c1_dvalid_drop", 32'(DVALID), 32'h0);
        chk("c1_dv_pulses", 32'(dv_cnt), 32'd1);

        // Case 3: parity error still delivers the word.
        send_frame(FR_PBAD, 1'b0);
        chk("c3_dvalid", 32'(DVALID), 32'h1);
        chk("c3_perr", 32'(PERR), 32'h1);
        chk("c3_dout", 32'(DOUT), 32'h16);
        step(1'b0, 1'b1);

        // Case 2: LSB first; PERR clears.
        LR = 1'b0;
        send_frame(FR_GOOD, 1'b0);
        chk("c2_dout", 32'(DOUT), 32'h0D);
        chk("c2_perr", 32'(PERR), 32'h0);
        step(1'b0, 1'b1);

        // Prime DOUT/PERR with a parity-bad MSB-first word before the framing error.
        LR = 1'b1;
        send_frame(FR_PBAD, 1'b0);
        chk("c4_pre_perr", 32'(PERR), 32'h1);

        // Case 4: stop bit 1 -> FERR, outputs held, trailing 1 is not a start.
        send_frame(FR_SBAD, 1'b0);
        chk("c4_ferr", 32'(FERR), 32'h1);
        chk("c4_dvalid", 32'(DVALID), 32'h0);
        chk("c4_dout_hold", 32'(DOUT), 32'h16);
        chk("c4_perr_hold", 32'(PERR), 32'h1);
        chk("c4_busy", 32'(BUSY), 32'h0);
        step(1'b1, 1'b1);
        chk("c4_ferr_drop", 32'(FERR), 32'h0);
        chk("c4_new_start", 32'(BUSY), 32'h1);
        for (int i = 6; i >= 0; i--) step(FR_GOOD[i], 1'b1);
        chk("c4_after_dout", 32'(DOUT), 32'h16);
        chk("c4_after_perr", 32'(PERR), 32'h0);
        chk("c4_fe_pulses", 32'(fe_cnt), 32'd1);
        step(1'b0, 1'b1);

        // Case 5: reset after three data bits.
        LR = 1'b0;
        for (int i = 7; i >= 4; i--) step(FR_GOOD[i], 1'b1);
        chk("c5_busy_mid", 32'(BUSY), 32'h1);
        RST = 1'b0;
        step(1'b0, 1'b1);
        RST = 1'b1;
        chk("c5_busy", 32'(BUSY), 32'h0);
        chk("c5_dout", 32'(DOUT), 32'h0);
        chk("c5_perr", 32'(PERR), 32'h0);
        chk("c5_dvalid", 32'(DVALID), 32'h0);
        chk("c5_ferr", 32'(FERR), 32'h0);
        LR = 1'b1;
        send_frame(FR_GOOD, 1'b0);
        chk("c5_frame_dout", 32'(DOUT), 32'h16);
        chk("c5_frame_dvalid", 32'(DVALID), 32'h1);
        step(1'b0, 1'b1);

        // Case 6: EN every other cycle, back-to-back frames, LR toggled mid-frame.
        dv_cnt = 0;
        LR = 1'b1;
        send_frame(FR_GOOD, 1'b1);
        chk("c6a_dout", 32'(DOUT), 32'h16);
        chk("c6a_perr", 32'(PERR), 32'h0);
        chk("c6a_dvalid", 32'(DVALID), 32'h1);
        LR = 1'b0;
        step(1'b1, 1'b0);
        chk("c6_dvalid_en0", 32'(DVALID), 32'h0);
        step(FR_GOOD[7], 1'b1);
        chk("c6b_start", 32'(BUSY), 32'h1);
        LR = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            step(1'($urandom), 1'b0);
            step(FR_GOOD[i], 1'b1);
        end
        chk("c6b_dout", 32'(DOUT), 32'h0D);
        chk("c6b_perr", 32'(PERR), 32'h0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("c6_dv_pulses", 32'(dv_cnt), 32'd2);
        chk("c6_dout_hold", 32'(DOUT), 32'h0D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
